// File: rtl/snake_cell_map_if.sv
// ============================================================================
// Module      : snake_cell_map_if
// Description : Pixel-write, clear and cell-query bus of the snake cell map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snake_cell_map_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear;
    logic       busy;
    logic       q_req;
    logic [3:0] q_cx;
    logic [3:0] q_cy;
    logic       q_ack;
    logic [2:0] q_colour;
    logic       q_hit;

    modport master (
        output plot, x, y, colour, clear, q_req, q_cx, q_cy,
        input  busy, q_ack, q_colour, q_hit
    );

    modport slave (
        input  plot, x, y, colour, clear, q_req, q_cx, q_cy,
        output busy, q_ack, q_colour, q_hit
    );
endinterface

`default_nettype wire

// File: rtl/snake_cell_map.sv
// ============================================================================
// Module      : snake_cell_map
// Description : Folds 160x120 pixel writes into a 16x12 map of colour cells
//               with a clear sweep and a one-cycle cell query port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_cell_map #(
    parameter int         XCELLS = 16,
    parameter int         YCELLS = 12,
    parameter int         CELL   = 10,
    parameter logic [2:0] BG     = 3'b000
) (
    input  wire              CLOCK_50,
    input  wire              Resetn,
    snake_cell_map_if.slave  bus
);
    localparam int         c_NCELLS = XCELLS * YCELLS;
    localparam logic [7:0] c_CELL8  = 8'(CELL);
    localparam logic [7:0] c_XC8    = 8'(XCELLS);
    localparam logic [7:0] c_YC8    = 8'(YCELLS);
    localparam logic [7:0] c_XPIX   = 8'(XCELLS * CELL);
    localparam logic [7:0] c_YPIX   = 8'(YCELLS * CELL);
    localparam logic [7:0] c_LAST   = 8'(c_NCELLS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_sweep;
    logic [2:0] r_cells [c_NCELLS];
    logic       r_q_ack;
    logic [2:0] r_q_colour;
    logic       r_q_hit;

    logic [7:0] w_px;
    logic [7:0] w_py;
    logic [7:0] w_cx;
    logic [7:0] w_cy;
    logic [7:0] w_widx;
    logic       w_aligned;
    logic       w_inrange;
    logic       w_we;
    logic [7:0] w_qcx;
    logic [7:0] w_qcy;
    logic [7:0] w_ridx;
    logic       w_wall;
    logic [2:0] w_rd;
    logic       w_idle;

    assign w_idle = (r_state == S_IDLE);

    // A pixel lands on a cell only if it is that cell's top-left corner.
    assign w_px      = bus.x;
    assign w_py      = {1'b0, bus.y};
    assign w_cx      = w_px / c_CELL8;
    assign w_cy      = w_py / c_CELL8;
    assign w_aligned = (w_px == w_cx * c_CELL8) && (w_py == w_cy * c_CELL8);
    assign w_inrange = (w_px < c_XPIX) && (w_py < c_YPIX);
    assign w_widx    = w_cy * c_XC8 + w_cx;
    assign w_we      = bus.plot && w_idle && w_inrange && w_aligned;

    assign w_qcx  = {4'b0000, bus.q_cx};
    assign w_qcy  = {4'b0000, bus.q_cy};
    assign w_wall = (w_qcx >= c_XC8) || (w_qcy >= c_YC8);
    assign w_ridx = w_qcy * c_XC8 + w_qcx;

    always_comb begin
        w_rd = BG;
        for (int k = 0; k < c_NCELLS; k++) begin
            if (w_ridx == 8'(k)) begin
                w_rd = r_cells[k];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_sweep <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clear) begin
                        r_state <= S_CLEAR;
                        r_sweep <= 8'd0;
                    end
                end
                S_CLEAR: begin
                    r_sweep <= r_sweep + 8'd1;
                    if (r_sweep == c_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The sweep owns the array while it runs; plots are gated off by w_idle.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < c_NCELLS; k++) begin
                r_cells[k] <= BG;
            end
        end else begin
            for (int k = 0; k < c_NCELLS; k++) begin
                if ((r_state == S_CLEAR) && (r_sweep == 8'(k))) begin
                    r_cells[k] <= BG;
                end else if (w_we && (w_widx == 8'(k))) begin
                    r_cells[k] <= bus.colour;
                end
            end
        end
    end

    // Reads the pre-edge array, so a same-cycle write is not yet visible.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_q_ack    <= 1'b0;
            r_q_colour <= 3'b000;
            r_q_hit    <= 1'b0;
        end else begin
            r_q_ack <= bus.q_req && w_idle;
            if (bus.q_req && w_idle) begin
                if (w_wall) begin
                    r_q_colour <= BG;
                    r_q_hit    <= 1'b1;
                end else begin
                    r_q_colour <= w_rd;
                    r_q_hit    <= (w_rd != BG);
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_CLEAR);
    assign bus.q_ack    = r_q_ack;
    assign bus.q_colour = r_q_colour;
    assign bus.q_hit    = r_q_hit;

endmodule

`default_nettype wire
